// File: rtl/user_adder_pkg.sv
// Shared definitions for the c0 stream adder: register map, control bits,
// lane count helper and the skid-buffer state encoding.
package user_adder_pkg;

  localparam int DEF_AXI_DATA_BITS = 512;
  localparam int ADD_LANES         = DEF_AXI_DATA_BITS / 32;

  localparam logic [63:0] ID_VALUE_DEF = 64'hADD0_C000_0000_0001;

  // Register word offsets, selected by addr[5:3]
  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_ADD_CONST = 3'd1;
  localparam logic [2:0] REG_BEAT_CNT  = 3'd2;
  localparam logic [2:0] REG_PKT_CNT   = 3'd3;
  localparam logic [2:0] REG_ID        = 3'd4;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_CLR_BIT    = 1;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

  function automatic int lanes_for(input int data_bits);
    return data_bits / 32;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register slice (main + skid). Output and s_tready are
// both driven straight from flops, so no combinational path from m_tready.
module axis_skid_buffer
  import user_adder_pkg::*;
#(
  parameter int DATA_BITS = 512,
  parameter int KEEP_BITS = 64,
  parameter int ID_BITS   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] s_tdata,
  input  logic [KEEP_BITS-1:0] s_tkeep,
  input  logic [ID_BITS-1:0]   s_tid,
  input  logic                 s_tlast,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  output logic [DATA_BITS-1:0] m_tdata,
  output logic [KEEP_BITS-1:0] m_tkeep,
  output logic [ID_BITS-1:0]   m_tid,
  output logic                 m_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready
);

  localparam int PAYLOAD_BITS = DATA_BITS + KEEP_BITS + ID_BITS + 1;

  buf_state_t              state_reg, state_next;
  logic [PAYLOAD_BITS-1:0] main_reg, skid_reg;
  logic [PAYLOAD_BITS-1:0] s_payload;
  logic                    m_valid_reg, ready_reg;
  logic                    accept, drain;
  logic                    load_main_in, load_main_skid, load_skid;

  assign s_payload = {s_tdata, s_tkeep, s_tid, s_tlast};
  assign accept    = s_tvalid & ready_reg;
  assign drain     = m_valid_reg & m_tready;

  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_reg)
      BUF_EMPTY: begin
        if (accept) begin
          state_next   = BUF_ONE;
          load_main_in = 1'b1;
        end
      end
      BUF_ONE: begin
        if (accept && !drain) begin
          state_next = BUF_FULL;
          load_skid  = 1'b1;
        end else if (!accept && drain) begin
          state_next = BUF_EMPTY;
        end else if (accept && drain) begin
          load_main_in = 1'b1;
        end
      end
      BUF_FULL: begin
        // ready is low here, so only a drain can happen
        if (drain) begin
          state_next     = BUF_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_next = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= BUF_EMPTY;
      main_reg    <= '0;
      skid_reg    <= '0;
      m_valid_reg <= 1'b0;
      ready_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load_main_in) begin
        main_reg <= s_payload;
      end else if (load_main_skid) begin
        main_reg <= skid_reg;
      end
      if (load_skid) begin
        skid_reg <= s_payload;
      end
      m_valid_reg <= (state_next != BUF_EMPTY);
      ready_reg   <= (state_next != BUF_FULL);
    end
  end

  assign s_tready = ready_reg;
  assign m_tvalid = m_valid_reg;
  assign {m_tdata, m_tkeep, m_tid, m_tlast} = main_reg;

endmodule

// File: rtl/user_stream_adder_c0.sv
// vFPGA c0 user stage: adds a programmable constant to every 32-bit lane of
// the host stream, with control, status and counters on AXI4-Lite.
module user_stream_adder_c0
  import user_adder_pkg::*;
#(
  parameter int          AXI_DATA_BITS  = 512,
  parameter int          AXIL_DATA_BITS = 64,
  parameter int          AXI_ADDR_BITS  = 64,
  parameter int          PID_BITS       = 6,
  parameter logic [63:0] ID_VALUE       = ID_VALUE_DEF
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [AXI_ADDR_BITS-1:0]      axi_ctrl_awaddr,
  input  logic                          axi_ctrl_awvalid,
  output logic                          axi_ctrl_awready,
  input  logic [AXIL_DATA_BITS-1:0]     axi_ctrl_wdata,
  input  logic [AXIL_DATA_BITS/8-1:0]   axi_ctrl_wstrb,
  input  logic                          axi_ctrl_wvalid,
  output logic                          axi_ctrl_wready,
  output logic [1:0]                    axi_ctrl_bresp,
  output logic                          axi_ctrl_bvalid,
  input  logic                          axi_ctrl_bready,
  input  logic [AXI_ADDR_BITS-1:0]      axi_ctrl_araddr,
  input  logic                          axi_ctrl_arvalid,
  output logic                          axi_ctrl_arready,
  output logic [AXIL_DATA_BITS-1:0]     axi_ctrl_rdata,
  output logic [1:0]                    axi_ctrl_rresp,
  output logic                          axi_ctrl_rvalid,
  input  logic                          axi_ctrl_rready,
  input  logic [AXI_DATA_BITS-1:0]      s_axis_host_sink_tdata,
  input  logic [AXI_DATA_BITS/8-1:0]    s_axis_host_sink_tkeep,
  input  logic [PID_BITS-1:0]           s_axis_host_sink_tid,
  input  logic                          s_axis_host_sink_tlast,
  input  logic                          s_axis_host_sink_tvalid,
  output logic                          s_axis_host_sink_tready,
  output logic [AXI_DATA_BITS-1:0]      m_axis_host_src_tdata,
  output logic [AXI_DATA_BITS/8-1:0]    m_axis_host_src_tkeep,
  output logic [PID_BITS-1:0]           m_axis_host_src_tid,
  output logic                          m_axis_host_src_tlast,
  output logic                          m_axis_host_src_tvalid,
  input  logic                          m_axis_host_src_tready
);

  localparam int LANES = lanes_for(AXI_DATA_BITS);

  // Reset asserts immediately, releases on a clock edge
  logic [1:0] rst_pipe;
  logic       rst;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rst_pipe <= 2'b11;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b0};
    end
  end

  assign rst = rst_pipe[1];

  logic                      enable_reg;
  logic [31:0]               add_const_reg, add_const_wr;
  logic [63:0]               beat_cnt_reg, pkt_cnt_reg;
  logic                      awready_reg, bvalid_reg, arready_reg, rvalid_reg;
  logic [AXIL_DATA_BITS-1:0] rdata_reg;
  logic [63:0]               rd_word;
  logic [2:0]                wr_sel, rd_sel;
  logic                      wr_fire, rd_fire, clr_cnt, sink_accept;
  logic [AXI_DATA_BITS-1:0]  sum_data;

  assign wr_sel  = axi_ctrl_awaddr[5:3];
  assign rd_sel  = axi_ctrl_araddr[5:3];
  assign wr_fire = awready_reg & axi_ctrl_awvalid & axi_ctrl_wvalid;
  assign rd_fire = arready_reg & axi_ctrl_arvalid;
  assign clr_cnt = wr_fire && (wr_sel == REG_CTRL) && axi_ctrl_wstrb[0]
                   && axi_ctrl_wdata[CTRL_CLR_BIT];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_const_byte
      assign add_const_wr[gi*8 +: 8] = axi_ctrl_wstrb[gi] ? axi_ctrl_wdata[gi*8 +: 8]
                                                          : add_const_reg[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      awready_reg   <= 1'b0;
      bvalid_reg    <= 1'b0;
      enable_reg    <= 1'b0;
      add_const_reg <= '0;
    end else begin
      awready_reg <= axi_ctrl_awvalid & axi_ctrl_wvalid & ~bvalid_reg & ~awready_reg;
      if (wr_fire) begin
        bvalid_reg <= 1'b1;
      end else if (axi_ctrl_bready) begin
        bvalid_reg <= 1'b0;
      end
      if (wr_fire && (wr_sel == REG_CTRL) && axi_ctrl_wstrb[0]) begin
        enable_reg <= axi_ctrl_wdata[CTRL_ENABLE_BIT];
      end
      if (wr_fire && (wr_sel == REG_ADD_CONST)) begin
        add_const_reg <= add_const_wr;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (rd_sel)
      REG_CTRL:      rd_word[CTRL_ENABLE_BIT] = enable_reg;
      REG_ADD_CONST: rd_word[31:0] = add_const_reg;
      REG_BEAT_CNT:  rd_word = beat_cnt_reg;
      REG_PKT_CNT:   rd_word = pkt_cnt_reg;
      REG_ID:        rd_word = ID_VALUE;
      default:       rd_word = '0;
    endcase
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      arready_reg <= axi_ctrl_arvalid & ~rvalid_reg & ~arready_reg;
      if (rd_fire) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_word[AXIL_DATA_BITS-1:0];
      end else if (axi_ctrl_rready) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  assign axi_ctrl_awready = awready_reg;
  assign axi_ctrl_wready  = awready_reg;
  assign axi_ctrl_bvalid  = bvalid_reg;
  assign axi_ctrl_bresp   = 2'b00;
  assign axi_ctrl_arready = arready_reg;
  assign axi_ctrl_rvalid  = rvalid_reg;
  assign axi_ctrl_rdata   = rdata_reg;
  assign axi_ctrl_rresp   = 2'b00;

  assign sink_accept = s_axis_host_sink_tvalid & s_axis_host_sink_tready;

  // A clear on the same edge as an accepted beat wins over the increment
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      beat_cnt_reg <= '0;
      pkt_cnt_reg  <= '0;
    end else if (clr_cnt) begin
      beat_cnt_reg <= '0;
      pkt_cnt_reg  <= '0;
    end else if (sink_accept) begin
      beat_cnt_reg <= beat_cnt_reg + 64'd1;
      if (s_axis_host_sink_tlast) begin
        pkt_cnt_reg <= pkt_cnt_reg + 64'd1;
      end
    end
  end

  // Lanes are summed on the way into the buffer, so buffered beats keep
  // the constant that was live when they were accepted
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign sum_data[gi*32 +: 32] = enable_reg
          ? s_axis_host_sink_tdata[gi*32 +: 32] + add_const_reg
          : s_axis_host_sink_tdata[gi*32 +: 32];
    end
  endgenerate

  axis_skid_buffer #(
    .DATA_BITS (AXI_DATA_BITS),
    .KEEP_BITS (AXI_DATA_BITS/8),
    .ID_BITS   (PID_BITS)
  ) u_skid (
    .clk      (aclk),
    .rst      (rst),
    .s_tdata  (sum_data),
    .s_tkeep  (s_axis_host_sink_tkeep),
    .s_tid    (s_axis_host_sink_tid),
    .s_tlast  (s_axis_host_sink_tlast),
    .s_tvalid (s_axis_host_sink_tvalid),
    .s_tready (s_axis_host_sink_tready),
    .m_tdata  (m_axis_host_src_tdata),
    .m_tkeep  (m_axis_host_src_tkeep),
    .m_tid    (m_axis_host_src_tid),
    .m_tlast  (m_axis_host_src_tlast),
    .m_tvalid (m_axis_host_src_tvalid),
    .m_tready (m_axis_host_src_tready)
  );

  logic unused_bits;
  assign unused_bits = ^{axi_ctrl_awaddr[AXI_ADDR_BITS-1:6], axi_ctrl_awaddr[2:0],
                         axi_ctrl_araddr[AXI_ADDR_BITS-1:6], axi_ctrl_araddr[2:0],
                         axi_ctrl_wdata[AXIL_DATA_BITS-1:32],
                         axi_ctrl_wstrb[AXIL_DATA_BITS/8-1:4]};

endmodule

// File: tb/tb_user_stream_adder_c0.sv
// Directed bench for user_stream_adder_c0: register access, lane add with wrap,
// backpressure, counters with clear collision and mid-packet reset.
module tb_user_stream_adder_c0;

  logic         aclk = 1'b0;
  logic         areset;
  logic [63:0]  awaddr, wdata, araddr;
  logic [7:0]   wstrb;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [63:0]  rdata;
  logic [511:0] sink_tdata, src_tdata;
  logic [63:0]  sink_tkeep, src_tkeep;
  logic [5:0]   sink_tid, src_tid;
  logic         sink_tlast, sink_tvalid, sink_tready;
  logic         src_tlast, src_tvalid, src_tready;

  always #5 aclk = ~aclk;

  user_stream_adder_c0 dut (
    .aclk                    (aclk),
    .areset                  (areset),
    .axi_ctrl_awaddr         (awaddr),
    .axi_ctrl_awvalid        (awvalid),
    .axi_ctrl_awready        (awready),
    .axi_ctrl_wdata          (wdata),
    .axi_ctrl_wstrb          (wstrb),
    .axi_ctrl_wvalid         (wvalid),
    .axi_ctrl_wready         (wready),
    .axi_ctrl_bresp          (bresp),
    .axi_ctrl_bvalid         (bvalid),
    .axi_ctrl_bready         (bready),
    .axi_ctrl_araddr         (araddr),
    .axi_ctrl_arvalid        (arvalid),
    .axi_ctrl_arready        (arready),
    .axi_ctrl_rdata          (rdata),
    .axi_ctrl_rresp          (rresp),
    .axi_ctrl_rvalid         (rvalid),
    .axi_ctrl_rready         (rready),
    .s_axis_host_sink_tdata  (sink_tdata),
    .s_axis_host_sink_tkeep  (sink_tkeep),
    .s_axis_host_sink_tid    (sink_tid),
    .s_axis_host_sink_tlast  (sink_tlast),
    .s_axis_host_sink_tvalid (sink_tvalid),
    .s_axis_host_sink_tready (sink_tready),
    .m_axis_host_src_tdata   (src_tdata),
    .m_axis_host_src_tkeep   (src_tkeep),
    .m_axis_host_src_tid     (src_tid),
    .m_axis_host_src_tlast   (src_tlast),
    .m_axis_host_src_tvalid  (src_tvalid),
    .m_axis_host_src_tready  (src_tready)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [511:0] in_data  [0:63];
  logic [511:0] exp_data [0:63];
  logic [63:0]  in_keep  [0:63];
  logic [5:0]   in_id    [0:63];
  logic         in_last  [0:63];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rep(input logic [31:0] v);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  // Write; optionally presents a prepared sink beat on the handshake edge
  task automatic axil_write(input logic [63:0] addr, input logic [63:0] data,
                            input logic [7:0] strb, input bit with_beat,
                            output logic out_valid, output logic [511:0] out_data);
    bit got = 0;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge aclk);
      if (awready && wready) got = 1;
    end
    chk("aw_handshake", got, 1);
    if (with_beat) begin
      chk("sink_ready_at_wr", sink_tready, 1);
      sink_tvalid = 1'b1;
    end
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; sink_tvalid = 1'b0; bready = 1'b1;
    out_valid = src_tvalid; out_data = src_tdata;
    chk("bvalid", bvalid, 1);
    chk("bresp", bresp, 0);
    @(negedge aclk);
    bready = 1'b0;
    chk("bvalid_clear", bvalid, 0);
    $display("write addr=%h data=%h strb=%h", addr, data, strb);
  endtask

  task automatic axil_read(input logic [63:0] addr, input logic [63:0] exp);
    bit got = 0;
    araddr = addr; arvalid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge aclk);
      if (arready) got = 1;
    end
    chk("ar_handshake", got, 1);
    @(negedge aclk);
    arvalid = 1'b0; rready = 1'b1;
    chk("rvalid", rvalid, 1);
    chk("rresp", rresp, 0);
    chk($sformatf("rdata@%0h", addr), rdata, exp);
    $display("read  addr=%h data=%h", addr, rdata);
    @(negedge aclk);
    rready = 1'b0;
  endtask

  // Streams n prepared beats; src_tready is held low for the first 'hold' cycles
  task automatic stream(input int n, input int hold, input string tag);
    int in_i = 0, out_i = 0, first_acc = -1, first_out = -1, last_out = -1;
    logic [511:0] prev_data = '0;
    bit prev_stall = 0;
    for (int cyc = 0; cyc < 2*n + hold + 20 && out_i < n; cyc++) begin
      src_tready = (cyc >= hold);
      if (prev_stall) begin
        chk({tag, "_hold_valid"}, src_tvalid, 1);
        chk({tag, "_hold_data"}, src_tdata, prev_data);
      end
      if (hold > 0 && cyc == hold) begin
        chk({tag, "_accepts_stalled"}, in_i, 2);
        chk({tag, "_sink_ready_low"}, sink_tready, 0);
      end
      if (src_tvalid && src_tready) begin
        chk($sformatf("%s_data%0d", tag, out_i), src_tdata, exp_data[out_i]);
        chk($sformatf("%s_keep%0d", tag, out_i), src_tkeep, in_keep[out_i]);
        chk($sformatf("%s_id%0d", tag, out_i), src_tid, in_id[out_i]);
        chk($sformatf("%s_last%0d", tag, out_i), src_tlast, in_last[out_i]);
        $display("%s beat %0d out data[31:0]=%h last=%b", tag, out_i, src_tdata[31:0], src_tlast);
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        out_i++;
      end
      prev_stall = src_tvalid && !src_tready;
      prev_data = src_tdata;
      if (in_i < n) begin
        sink_tdata = in_data[in_i]; sink_tkeep = in_keep[in_i];
        sink_tid = in_id[in_i]; sink_tlast = in_last[in_i]; sink_tvalid = 1'b1;
        if (sink_tready) begin
          if (first_acc < 0) first_acc = cyc;
          in_i++;
        end
      end else begin
        sink_tvalid = 1'b0;
      end
      @(negedge aclk);
    end
    sink_tvalid = 1'b0;
    src_tready = 1'b1;
    chk({tag, "_out_count"}, out_i, n);
    chk({tag, "_no_dup"}, src_tvalid, 0);
    if (hold == 0) begin
      chk({tag, "_latency"}, first_out - first_acc, 1);
      chk({tag, "_throughput"}, last_out, n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic         ov;
    logic [511:0] od;
    areset = 1'b1;
    awaddr = '0; wdata = '0; wstrb = '0; awvalid = 0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0;
    sink_tdata = '0; sink_tkeep = '0; sink_tid = '0; sink_tlast = 0; sink_tvalid = 0;
    src_tready = 1'b1;

    // Reset state
    repeat (3) @(negedge aclk);
    chk("rst_src_tvalid", src_tvalid, 0);
    chk("rst_sink_tready", sink_tready, 0);
    chk("rst_awready", awready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_src_tdata", src_tdata, 0);
    areset = 1'b0;
    repeat (4) @(negedge aclk);
    chk("post_rst_sink_tready", sink_tready, 1);

    axil_read(64'h20, 64'hADD0_C000_0000_0001);
    axil_read(64'h00, 64'h0);

    // Pass-through, enable = 0
    for (int i = 0; i < 3; i++) begin
      in_data[i] = rep(32'h1); exp_data[i] = rep(32'h1);
      in_keep[i] = '1; in_id[i] = 6'd5; in_last[i] = (i == 2);
    end
    stream(3, 0, "pass");

    // Add with wrap
    axil_write(64'h08, 64'h0000_0000_FFFF_FFFF, 8'hFF, 0, ov, od);
    axil_write(64'h00, 64'h1, 8'hFF, 0, ov, od);
    axil_read(64'h00, 64'h1);
    in_data[0] = rep(32'h2); exp_data[0] = rep(32'h1);
    in_keep[0] = 64'h00FF_FFFF_0000_FFFF; in_id[0] = 6'd3; in_last[0] = 1'b1;
    stream(1, 0, "wrap");

    // Byte strobes and upper-half read-as-zero on ADD_CONST
    axil_write(64'h08, 64'h1111_1111_2222_2222, 8'h01, 0, ov, od);
    axil_read(64'h08, 64'h0000_0000_FFFF_FF22);
    axil_write(64'h08, 64'hFFFF_FFFF_0000_0010, 8'hFF, 0, ov, od);
    axil_read(64'h08, 64'h0000_0000_0000_0010);
    axil_read(64'h38, 64'h0);

    // Backpressure, enable = 1, const = 0x10
    for (int i = 0; i < 4; i++) begin
      in_data[i] = rep(32'd100 + i); exp_data[i] = rep(32'd116 + i);
      in_keep[i] = '1; in_id[i] = 6'(i); in_last[i] = (i == 3);
    end
    stream(4, 5, "bp");

    // Counters: clear (enable off), 10 packets x 4 beats
    axil_write(64'h00, 64'h2, 8'hFF, 0, ov, od);
    axil_read(64'h00, 64'h0);
    axil_read(64'h10, 64'h0);
    for (int i = 0; i < 40; i++) begin
      in_data[i] = rep(32'(i * 7 + 3)); exp_data[i] = rep(32'(i * 7 + 3));
      in_keep[i] = '1; in_id[i] = 6'(i % 4); in_last[i] = ((i % 4) == 3);
    end
    stream(40, 0, "cnt");
    axil_read(64'h10, 64'd40);
    axil_read(64'h18, 64'd10);

    // CTRL = 3 on the same edge as an accepted tlast beat
    sink_tdata = rep(32'h55); sink_tkeep = '1; sink_tid = 6'd1; sink_tlast = 1'b1;
    axil_write(64'h00, 64'h3, 8'hFF, 1, ov, od);
    chk("collide_beat_valid", ov, 1);
    chk("collide_beat_old_enable", od, rep(32'h55));
    axil_read(64'h10, 64'h0);
    axil_read(64'h18, 64'h0);
    axil_read(64'h00, 64'h1);
    in_data[0] = rep(32'h5); exp_data[0] = rep(32'h15);
    in_keep[0] = '1; in_id[0] = 6'd2; in_last[0] = 1'b1;
    stream(1, 0, "after_en");

    // Reset with two beats buffered
    src_tready = 1'b0;
    sink_tdata = rep(32'hA0); sink_tkeep = '1; sink_tid = 6'd7; sink_tlast = 1'b0;
    sink_tvalid = 1'b1;
    @(negedge aclk);
    sink_tdata = rep(32'hA1);
    @(negedge aclk);
    chk("pre_rst_full_sink_ready", sink_tready, 0);
    chk("pre_rst_src_tvalid", src_tvalid, 1);
    sink_tvalid = 1'b0;
    #2 areset = 1'b1;
    #1;
    chk("midrst_src_tvalid", src_tvalid, 0);
    chk("midrst_sink_tready", sink_tready, 0);
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    src_tready = 1'b1;
    repeat (4) @(negedge aclk);
    chk("after_rst_src_tvalid", src_tvalid, 0);
    axil_read(64'h10, 64'h0);
    axil_read(64'h18, 64'h0);
    axil_read(64'h00, 64'h0);
    axil_read(64'h08, 64'h0);
    for (int i = 0; i < 2; i++) begin
      in_data[i] = rep(32'h9 + i); exp_data[i] = rep(32'h9 + i);
      in_keep[i] = '1; in_id[i] = 6'd4; in_last[i] = (i == 1);
    end
    stream(2, 0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
